// File: rtl/lvdc_clk_pkg.sv
// lvdc_clk_pkg: FSM states, phase indices and tick-counter width helper for multiphase_clock_gen.
package lvdc_clk_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  localparam int PH_W = 0;
  localparam int PH_X = 1;
  localparam int PH_Y = 2;
  localparam int PH_Z = 3;
  function automatic int tick_w(input int hi, input int gap);
    int m;
    m = hi > gap ? hi : gap;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/clk_phase_fanout.sv
// clk_phase_fanout: registers one clock phase and drives its fanout, delay-line and inverted copies.
module clk_phase_fanout #(
  parameter int FANOUT = 8
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              i_ph,
  output logic              o_ph,
  output logic              o_phda,
  output logic              o_phn,
  output logic [FANOUT-1:0] o_fan
);
  logic r_ph;
  always_ff @(posedge SIM_CLK) r_ph <= SIM_RST ? 1'b0 : i_ph;
  assign o_ph   = r_ph;
  assign o_phda = r_ph;
  assign o_phn  = ~r_ph;
  assign o_fan  = {FANOUT{r_ph}};
endmodule

// File: rtl/multiphase_clock_gen.sv
// multiphase_clock_gen: NPHASE non-overlapping one-hot clock phases with programmable width and gap.
// Define SINGLE_STEP_EN to let STEP run exactly one full cycle from IDLE.
module multiphase_clock_gen
  import lvdc_clk_pkg::*;
#(
  parameter int NPHASE     = 4,
  parameter int FANOUT     = 8,
  parameter int HIGH_TICKS = 2,
  parameter int GAP_TICKS  = 1,
  parameter int CYC_W      = 16
) (
  input  logic                     SIM_CLK,
  input  logic                     SIM_RST,
  input  logic                     BOP,
  input  logic                     STEP,
  output logic [NPHASE-1:0]        PH,
  output logic [NPHASE-1:0]        PHDA,
  output logic [NPHASE-1:0]        PHN,
  output logic [NPHASE*FANOUT-1:0] PH_FAN,
  output logic                     CYC_END,
  output logic [CYC_W-1:0]         CYC_CNT,
  output logic                     RUNNING
);
  localparam int IW = $clog2(NPHASE);
  localparam int TW = tick_w(HIGH_TICKS, GAP_TICKS);
  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [TW-1:0]    r_tick;
  logic             r_inc;
  logic             r_cyc_end;
  logic             r_running;
  logic [CYC_W-1:0] r_cnt;
  logic             w_start;
  logic             w_hi_done;
  logic             w_gap_done;
  logic             w_last;
  logic             w_adv;
`ifdef SINGLE_STEP_EN
  assign w_start = BOP | STEP;
`else
  logic w_unused_step;
  assign w_unused_step = STEP;
  assign w_start       = BOP;
`endif
  assign w_hi_done  = r_tick == TW'(HIGH_TICKS - 1);
  assign w_gap_done = r_tick == TW'(GAP_TICKS - 1);
  assign w_last     = r_idx == IW'(NPHASE - 1);
  assign w_adv      = r_state == GAP ? w_gap_done : r_state == HIGH && w_hi_done && GAP_TICKS == 0;
  // Outputs are registered from the current state, so they trail the FSM by one edge.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_state   <= IDLE;
      r_idx     <= IW'(PH_W);
      r_tick    <= '0;
      r_inc     <= 1'b0;
      r_cyc_end <= 1'b0;
      r_running <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_tick    <= (r_state == IDLE || (r_state == HIGH ? w_hi_done : w_gap_done)) ? '0 : r_tick + TW'(1);
      r_cyc_end <= r_state == HIGH && w_hi_done && w_last;
      r_running <= r_state != IDLE;
      r_inc     <= w_adv && w_last;
      r_cnt     <= r_cnt + CYC_W'(r_inc);
      if (r_state == IDLE) r_state <= w_start ? HIGH : IDLE;
      else if (w_adv) begin
        r_state <= w_last && !BOP ? IDLE : HIGH;
        r_idx   <= w_last ? IW'(PH_W) : r_idx + IW'(1);
      end else if (r_state == HIGH && w_hi_done) r_state <= GAP;
    end
  end
  for (genvar p = 0; p < NPHASE; p++) begin : g_ph
    clk_phase_fanout #(.FANOUT(FANOUT)) u_ph (
      .SIM_CLK(SIM_CLK),
      .SIM_RST(SIM_RST),
      .i_ph   (r_state == HIGH && r_idx == IW'(p)),
      .o_ph   (PH[p]),
      .o_phda (PHDA[p]),
      .o_phn  (PHN[p]),
      .o_fan  (PH_FAN[p*FANOUT +: FANOUT])
    );
  end
  assign CYC_END = r_cyc_end;
  assign CYC_CNT = r_cnt;
  assign RUNNING = r_running;
endmodule

// File: tb/tb_multiphase_clock_gen.sv
// tb_multiphase_clock_gen: table-driven scoreboard bench for the default 4-phase build and a
// 6-phase abutting build with a 2-bit cycle counter.
module tb_multiphase_clock_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1, bop_a = 1'b0, rst_b = 1'b1, bop_b = 1'b0, step = 1'b0;
  logic [3:0]  ph_a, phda_a, phn_a;
  logic [31:0] fan_a;
  logic        ce_a, run_a;
  logic [15:0] cnt_a;
  logic [5:0]  ph_b, phda_b, phn_b;
  logic [11:0] fan_b;
  logic        ce_b, run_b;
  logic [1:0]  cnt_b;
  multiphase_clock_gen u_a (
    .SIM_CLK(clk), .SIM_RST(rst_a), .BOP(bop_a), .STEP(step),
    .PH(ph_a), .PHDA(phda_a), .PHN(phn_a), .PH_FAN(fan_a),
    .CYC_END(ce_a), .CYC_CNT(cnt_a), .RUNNING(run_a)
  );
  multiphase_clock_gen #(.NPHASE(6), .FANOUT(2), .HIGH_TICKS(1), .GAP_TICKS(0), .CYC_W(2)) u_b (
    .SIM_CLK(clk), .SIM_RST(rst_b), .BOP(bop_b), .STEP(step),
    .PH(ph_b), .PHDA(phda_b), .PHN(phn_b), .PH_FAN(fan_b),
    .CYC_END(ce_b), .CYC_CNT(cnt_b), .RUNNING(run_b)
  );
  typedef struct {
    bit          b;
    logic        rst, bop, stp;
    logic [5:0]  ph;
    logic        ce, run;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask
  function automatic vec_t mk(bit b, logic r, logic bo, logic s, logic [5:0] ph, logic ce, logic run, int cnt);
    vec_t v;
    v = '{b, r, bo, s, ph, ce, run, 16'(cnt)};
    return v;
  endfunction
  // Free-running default timing: 12-tick period, each phase 2 high + 1 low.
  function automatic vec_t run_a_row(int t, logic bop, logic s, int cnt);
    int pos;
    pos = (t - 1) % 12;
    return mk(0, 0, bop, s, (pos % 3 < 2) ? 6'(1 << (pos / 3)) : 6'd0, pos == 10, 1, cnt);
  endfunction
  always @(negedge clk) begin
    if (!$isunknown({ph_a, ph_b})) begin
      checks++;
      if (!$onehot0(ph_a) || !$onehot0(ph_b)) begin
        errors++;
        $display("FAIL onehot: got a=%b b=%b expected at most one bit", ph_a, ph_b);
      end
    end
  end
  initial begin
    repeat (3) tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    for (int t = 1; t <= 24; t++) tbl.push_back(run_a_row(t, t < 16, 0, t >= 13 ? 1 : 0));
    for (int t = 25; t <= 29; t++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2));
    for (int u = 1; u <= 7; u++) tbl.push_back(run_a_row(u, 1, 0, 2));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    for (int v = 1; v <= 4; v++) tbl.push_back(run_a_row(v, 1, 0, 0));
    repeat (2) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
    for (int t = 1; t <= 26; t++)
      tbl.push_back(mk(1, 0, 1, 0, 6'(1 << ((t - 1) % 6)), (t - 1) % 6 == 5, 1, ((t - 1) / 6) % 4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
`ifdef SINGLE_STEP_EN
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    for (int t = 1; t <= 12; t++) tbl.push_back(run_a_row(t, 0, t >= 4 && t <= 6, 0));
    for (int t = 13; t <= 16; t++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
`else
    for (int t = 0; t <= 4; t++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
`endif
    foreach (tbl[i]) begin
      vec_t e;
      @(negedge clk);
      if (!tbl[i].b) {rst_a, bop_a} = {tbl[i].rst, tbl[i].bop};
      else {rst_b, bop_b} = {tbl[i].rst, tbl[i].bop};
      step = tbl[i].stp;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (!e.b) begin
        chk($sformatf("row%0d PH", i), 32'(ph_a), 32'(e.ph[3:0]));
        chk($sformatf("row%0d PHDA", i), 32'(phda_a), 32'(e.ph[3:0]));
        chk($sformatf("row%0d PHN", i), 32'(phn_a), {28'b0, ~e.ph[3:0]});
        chk($sformatf("row%0d PH_FAN", i), fan_a, {{8{e.ph[3]}}, {8{e.ph[2]}}, {8{e.ph[1]}}, {8{e.ph[0]}}});
        chk($sformatf("row%0d CYC_END", i), 32'(ce_a), 32'(e.ce));
        chk($sformatf("row%0d RUNNING", i), 32'(run_a), 32'(e.run));
        chk($sformatf("row%0d CYC_CNT", i), 32'(cnt_a), 32'(e.cnt));
      end else begin
        chk($sformatf("row%0d B PH", i), 32'(ph_b), 32'(e.ph));
        chk($sformatf("row%0d B PHDA", i), 32'(phda_b), 32'(e.ph));
        chk($sformatf("row%0d B PHN", i), 32'(phn_b), {26'b0, ~e.ph});
        chk($sformatf("row%0d B PH_FAN", i), 32'(fan_b),
            {20'b0, {2{e.ph[5]}}, {2{e.ph[4]}}, {2{e.ph[3]}}, {2{e.ph[2]}}, {2{e.ph[1]}}, {2{e.ph[0]}}});
        chk($sformatf("row%0d B CYC_END", i), 32'(ce_b), 32'(e.ce));
        chk($sformatf("row%0d B RUNNING", i), 32'(run_b), 32'(e.run));
        chk($sformatf("row%0d B CYC_CNT", i), 32'(cnt_b), 32'(e.cnt[1:0]));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
